// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment patterns (bit6..0 = g..a) and the
// scan-decoder FSM encoding. Used by both the display encoder and the scan decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0011000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of one active-low segment pattern into a hex nibble.
// Exact matches only; the all-dark pattern is reported separately as blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    legal  = 1'b1;
    nibble = 4'h0;
    blank  = (seg == SEG_BLANK);
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed active-low 7-segment bus and recovers the nibble shown on each
// digit once the synchronised {anodes,segments} word has been stable for a full window.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   an_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   valid_o,
  output logic                    upd_o,
  output logic [2:0]              upd_idx_o,
  output logic                    err_o
);

  localparam int PW = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

  logic [PW-1:0] sync1, sync2, prev;
  logic          changed;
  logic [NUM_DIGITS-1:0] an_low;
  logic          one_low;
  logic [2:0]    sel;
  logic [CNT_W-1:0] cnt;
  scan_state_t   state_q, state_d;
  logic          commit;
  logic          legal, blank;
  logic [3:0]    nibble;
  logic [NUM_DIGITS-1:0][3:0] digits_q;

  // Reset to all-ones: the synchroniser starts out seeing a dark display.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      // NOTE: non-blocking, so each stage takes the previous stage's value from before the edge.
      sync1 <= {an_i, seg_i};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign changed = (sync2 != prev);
  assign an_low  = ~sync2[PW-1:7];
  assign one_low = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);

  always_comb begin
    sel = 3'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (an_low[k]) sel = 3'(k);
    end
  end

  seg7_decode u_decode (
    .seg    (sync2[6:0]),
    .legal  (legal),
    .blank  (blank),
    .nibble (nibble)
  );

  // Stability counter; held at zero in IDLE so a fresh window always starts from 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (changed || state_q == ST_IDLE) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Any change re-evaluates the anodes immediately, keeping commit latency independent of state.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (one_low) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (changed) begin
          state_d = one_low ? ST_TRACK : ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          commit  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (changed) state_d = one_low ? ST_TRACK : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the digit register file is reset because its reset value is visible on digits_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digits_q  <= '0;
      valid_o   <= '0;
      upd_o     <= 1'b0;
      err_o     <= 1'b0;
      upd_idx_o <= 3'd0;
    end else begin
      upd_o <= commit;
      err_o <= commit && !legal && !blank;
      if (commit) upd_idx_o <= sel;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (commit && sel == 3'(k)) begin
          valid_o[k] <= legal;
          if (legal) digits_q[k] <= nibble;
        end
      end
    end
  end

  assign digits_o = digits_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: reset, commit latency, full table scan, glitch
// rejection, illegal/blank commits, ghosting, commit-cycle boundary and mid-window reset.
module tb_seg7_scan_decoder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [6:0]  seg_i = 7'h7F;
  logic [3:0]  an_i  = 4'hF;
  logic [15:0] digits_o;
  logic [3:0]  valid_o;
  logic        upd_o;
  logic [2:0]  upd_idx_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .seg_i     (seg_i),
    .an_i      (an_i),
    .digits_o  (digits_o),
    .valid_o   (valid_o),
    .upd_o     (upd_o),
    .upd_idx_o (upd_idx_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    @(posedge clk_i);
    #1;
    an_i  = an;
    seg_i = seg;
  endtask

  // Observes n cycles at the falling edge; cycle 1 is the first rising edge after the drive.
  task automatic hold(input int n, output int first, output int nupd, output int nerr,
                      output logic [2:0] idx);
    first = 0;
    nupd  = 0;
    nerr  = 0;
    idx   = 3'd0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (upd_o) begin
        nupd++;
        if (first == 0) begin
          first = i;
          idx   = upd_idx_o;
        end
      end
      if (err_o) nerr++;
    end
  endtask

  initial begin
    int first, nupd, nerr, tot;
    logic [2:0] idx;
    logic [3:0] an_v;
    int k;

    // 1: reset with pins toggling, then a full window before the first commit
    an_i  = 4'b1110;
    seg_i = PAT[1];
    repeat (2) begin
      @(posedge clk_i);
      #1 seg_i = (seg_i == PAT[1]) ? PAT[3] : PAT[1];
    end
    @(negedge clk_i);
    check("rst_digits", 32'(digits_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_upd_err", {30'd0, upd_o, err_o}, 32'h0);
    check("rst_idx", 32'(upd_idx_o), 32'h0);
    seg_i = PAT[1];
    rst_i = 1'b0;
    hold(10, first, nupd, nerr, idx);
    check("rel_first_upd", 32'(first), 32'd7);
    check("rel_upd_count", 32'(nupd), 32'd1);

    // 2: digit 0 shows '2': one commit 6 cycles after the first sampling edge
    drive(4'b1111, 7'h7F);
    hold(4, first, nupd, nerr, idx);
    drive(4'b1110, 7'b0100100);
    hold(10, first, nupd, nerr, idx);
    check("t2_first_upd", 32'(first), 32'd7);
    check("t2_upd_count", 32'(nupd), 32'd1);
    check("t2_idx", 32'(idx), 32'd0);
    check("t2_digit0", 32'(digits_o[3:0]), 32'h2);
    check("t2_valid0", 32'(valid_o[0]), 32'h1);

    // 3: all 16 patterns scanned round-robin over digits 0..3
    for (int i = 0; i < 16; i++) begin
      k    = i % 4;
      an_v = ~(4'b0001 << k);
      drive(an_v, PAT[i]);
      hold(8, first, nupd, nerr, idx);
      check($sformatf("t3_upd_%0d", i), 32'(nupd), 32'd1);
      check($sformatf("t3_idx_%0d", i), 32'(idx), 32'(k));
      check($sformatf("t3_digit_%0d", i), 32'(digits_o[4*k +: 4]), 32'(i));
      check($sformatf("t3_valid_%0d", i), 32'(valid_o[k]), 32'h1);
    end
    check("t3_digits_all", 32'(digits_o), 32'hFEDC);
    check("t3_valid_all", 32'(valid_o), 32'hF);

    // 4: segments change every 3 cycles on digit 1, then settle on '1'
    tot = 0;
    for (int i = 2; i < 8; i++) begin
      drive(4'b1101, PAT[i]);
      hold(2, first, nupd, nerr, idx);
      tot += nupd;
    end
    check("t4_glitch_no_upd", 32'(tot), 32'd0);
    check("t4_digit1_held", 32'(digits_o[7:4]), 32'hD);
    drive(4'b1101, 7'b1111001);
    hold(10, first, nupd, nerr, idx);
    check("t4_upd_count", 32'(nupd), 32'd1);
    check("t4_idx", 32'(idx), 32'd1);
    check("t4_digit1", 32'(digits_o[7:4]), 32'h1);

    // 5: digit 2 gets '7', then an illegal pattern, then blank
    drive(4'b1011, 7'b1111000);
    hold(8, first, nupd, nerr, idx);
    check("t5_digit2_seven", 32'(digits_o[11:8]), 32'h7);
    drive(4'b1011, 7'b1010101);
    hold(8, first, nupd, nerr, idx);
    check("t5_ill_upd", 32'(nupd), 32'd1);
    check("t5_ill_err", 32'(nerr), 32'd1);
    check("t5_ill_valid2", 32'(valid_o[2]), 32'h0);
    check("t5_ill_digit2", 32'(digits_o[11:8]), 32'h7);
    drive(4'b1011, 7'b1111111);
    hold(8, first, nupd, nerr, idx);
    check("t5_blank_upd", 32'(nupd), 32'd1);
    check("t5_blank_err", 32'(nerr), 32'd0);
    check("t5_blank_valid2", 32'(valid_o[2]), 32'h0);
    check("t5_digits_all", 32'(digits_o), 32'hF71C);
    check("t5_valid_all", 32'(valid_o), 32'hB);

    // 6a: two anodes low (ghosting) never commits
    drive(4'b1100, 7'b0000000);
    hold(20, first, nupd, nerr, idx);
    check("t6_ghost_no_upd", 32'(nupd), 32'd0);
    check("t6_ghost_digits", 32'(digits_o), 32'hF71C);

    // 6b: held 4 samples -> S changes on the commit cycle, no commit; 5 samples -> commit
    drive(4'b0111, PAT[0]);
    hold(3, first, nupd, nerr, idx);
    tot = nupd;
    drive(4'b1111, 7'h7F);
    hold(10, first, nupd, nerr, idx);
    tot += nupd;
    check("t6_short_no_upd", 32'(tot), 32'd0);
    check("t6_short_digit3", 32'(digits_o[15:12]), 32'hF);
    drive(4'b0111, PAT[0]);
    hold(4, first, nupd, nerr, idx);
    tot = nupd;
    drive(4'b1111, 7'h7F);
    hold(10, first, nupd, nerr, idx);
    tot += nupd;
    check("t6_exact_upd", 32'(tot), 32'd1);
    check("t6_exact_digit3", 32'(digits_o[15:12]), 32'h0);

    // 6c: reset in the middle of a window discards it; commit restarts from scratch
    drive(4'b1110, PAT[8]);
    hold(4, first, nupd, nerr, idx);
    check("t6_pre_rst_no_upd", 32'(nupd), 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("t6_rst_digits", 32'(digits_o), 32'h0);
    check("t6_rst_valid", 32'(valid_o), 32'h0);
    rst_i = 1'b0;
    hold(10, first, nupd, nerr, idx);
    check("t6_post_rst_first", 32'(first), 32'd7);
    check("t6_post_rst_count", 32'(nupd), 32'd1);
    check("t6_post_rst_digit0", 32'(digits_o), 32'h0008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
